// File: rtl/ps2_keycode_receiver.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered lines, frame FSM,
// E0/F0 prefix tracking and a FWFT key-event FIFO. Optional PS2_PARITY_CHECK_EN enables odd-parity checking.
module ps2_keycode_receiver #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       dout_brk,
    output logic       dout_ext,
    output logic       empty,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0] raw_lines;
    logic [1:0] filt_lines;
    assign raw_lines = {ps2_data, ps2_clk};

    // A line level is accepted only after FILTER_LEN consecutive differing samples.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic [1:0]    sync_reg;
            logic [FW-1:0] cnt_reg;
            logic          filt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= 2'b11;
                    cnt_reg  <= '0;
                    filt_reg <= 1'b1;
                end else begin
                    sync_reg <= {sync_reg[0], raw_lines[gi]};
                    if (sync_reg[1] == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == FW'(FILTER_LEN - 1)) begin
                        filt_reg <= sync_reg[1];
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
            assign filt_lines[gi] = filt_reg;
        end
    endgenerate

    logic clk_prev_reg;
    logic strobe;
    logic data_bit;
    assign strobe   = clk_prev_reg & ~filt_lines[0];
    assign data_bit = filt_lines[1];

    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          ext_reg, brk_reg;
    logic          frame_err_reg;
    logic          timeout, byte_done, err, parity_ok, push;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_reg;
    assign parity_ok = ^{shift_reg, parity_reg};
`else
    assign parity_ok = 1'b1;
`endif

    assign timeout = (state_reg != IDLE) && (tmo_cnt_reg == TW'(TIMEOUT_CYC));

    always_comb begin
        state_next = state_reg;
        byte_done  = 1'b0;
        err        = 1'b0;
        if (timeout) begin
            state_next = IDLE;
            err        = 1'b1;
        end else if (strobe) begin
            case (state_reg)
                IDLE:    if (!data_bit) state_next = DATA;
                DATA:    if (bit_cnt_reg == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    if (data_bit && parity_ok) byte_done = 1'b1;
                    else                       err       = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign push = byte_done && (shift_reg != 8'hE0) && (shift_reg != 8'hF0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            clk_prev_reg  <= 1'b1;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            tmo_cnt_reg   <= '0;
            ext_reg       <= 1'b0;
            brk_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            clk_prev_reg  <= filt_lines[0];
            frame_err_reg <= err;
            if (state_reg == IDLE || strobe)   tmo_cnt_reg <= '0;
            else if (!timeout)                 tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            if (strobe && state_reg == IDLE) begin
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
            end
            if (strobe && state_reg == DATA) begin
                shift_reg   <= {data_bit, shift_reg[7:1]};
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
`ifdef PS2_PARITY_CHECK_EN
            if (strobe && state_reg == PARITY) parity_reg <= data_bit;
`endif
            if (err) begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end else if (byte_done) begin
                case (shift_reg)
                    8'hE0:   ext_reg <= 1'b1;
                    8'hF0:   brk_reg <= 1'b1;
                    default: begin
                        ext_reg <= 1'b0;
                        brk_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Event FIFO: asynchronous head read gives first-word-fall-through.
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic          full, pop, wr_ok;
    logic [9:0]    head;

    assign full  = (count_reg == CW'(FIFO_DEPTH));
    assign empty = (count_reg == '0);
    assign pop   = rd_en && !empty;
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_reg] <= {brk_reg, ext_reg, shift_reg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && full && !pop) overflow_reg <= 1'b1;
        end
    end

    assign head      = empty ? 10'd0 : mem[rd_ptr_reg];
    assign dout      = head[7:0];
    assign dout_ext  = head[8];
    assign dout_brk  = head[9];
    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;
endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// Self-checking bench for ps2_keycode_receiver: PS/2 frames driven bit by bit,
// expected key events produced by a queue-based model of the prefix/FIFO rules.
module tb_ps2_keycode_receiver;
    localparam int DEPTH = 4;
    localparam int FL    = 4;
    localparam int TMO   = 1500;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       dout_brk, dout_ext, empty, overflow, frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;

    logic [9:0] exp_q[$];
    logic       m_brk = 1'b0, m_ext = 1'b0, m_ovf = 1'b0;

    ps2_keycode_receiver #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .dout(dout), .dout_brk(dout_brk), .dout_ext(dout_ext), .empty(empty),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && frame_err) err_cnt++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: what a keyboard byte does to the event stream.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_brk, m_ext, b});
            else m_ovf = 1'b1;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic model_clear_flags();
        m_brk = 1'b0;
        m_ext = 1'b0;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
        return {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic ps2_send(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (HALF/2) @(negedge clk);
            if (glitch) begin
                ps2_clk = 1'b0;
                repeat (FL-1) @(negedge clk);
                ps2_clk = 1'b1;
            end
            repeat (HALF/2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF/2) @(negedge clk);
            if (glitch) begin
                ps2_clk = 1'b1;
                repeat (FL-1) @(negedge clk);
                ps2_clk = 1'b0;
            end
            repeat (HALF/2) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        ps2_send(frame_bits(b, bad_par), 11, glitch);
    endtask

    task automatic pop_event(output logic [9:0] ev, output logic was_empty);
        @(negedge clk);
        was_empty = empty;
        ev = {dout_brk, dout_ext, dout};
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        model_clear_flags();
        m_ovf = 1'b0;
        n_cmp++;
        if ({dout, dout_brk, dout_ext, empty, overflow, frame_err} !== {8'h00, 5'b00100}) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {dout, dout_brk, dout_ext, empty, overflow, frame_err}, {8'h00, 5'b00100});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({dout, dout_brk, dout_ext, empty, overflow, frame_err} !== {8'h00, 5'b00100}) begin
            n_bad++;
            $display("FAIL post_reset_outputs: got %h expected %h",
                     {dout, dout_brk, dout_ext, empty, overflow, frame_err}, {8'h00, 5'b00100});
        end
        $display("test_reset done");
    endtask

    task automatic test_make();
        logic [9:0] ev;
        logic       e;
        ps2_send(frame_bits(8'h1C, 1'b0), 10, 1'b0);
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        // 2 sync stages + FILTER_LEN samples, strobe cycle, then the push edge.
        repeat (FL+2) @(negedge clk);
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL make_empty_before_push: got %b expected 1", empty);
        end
        @(negedge clk);
        n_cmp++;
        if (empty !== 1'b0) begin
            n_bad++;
            $display("FAIL make_empty_after_push: got %b expected 0", empty);
        end
        repeat (HALF-FL-3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        model_byte(8'h1C);
        pop_event(ev, e);
        n_cmp++;
        if (e !== 1'b0 || ev !== exp_q[0]) begin
            n_bad++;
            $display("FAIL make_event: got %h empty=%b expected %h", ev, e, exp_q[0]);
        end
        void'(exp_q.pop_front());
        $display("test_make event %h", ev);
    endtask

    task automatic test_prefix();
        logic [9:0] ev, ex;
        logic       e;
        logic [7:0] seq [5] = '{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75};
        foreach (seq[i]) begin
            send_frame(seq[i], 1'b0, 1'b0);
            model_byte(seq[i]);
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            pop_event(ev, e);
            n_cmp++;
            if (e !== 1'b0 || ev !== ex) begin
                n_bad++;
                $display("FAIL prefix_event: got %h empty=%b expected %h", ev, e, ex);
            end
            $display("test_prefix event %h", ev);
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL prefix_empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_parity();
        logic [9:0] ev, ex;
        logic       e;
        int         err0;
        int         exp_err;
        err0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        exp_err = 1;
        model_clear_flags();
`else
        exp_err = 0;
        model_byte(8'h1C);
`endif
        n_cmp++;
        if (err_cnt - err0 !== exp_err) begin
            n_bad++;
            $display("FAIL parity_frame_err: got %0d pulses expected %0d", err_cnt - err0, exp_err);
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            pop_event(ev, e);
            n_cmp++;
            if (e !== 1'b0 || ev !== ex) begin
                n_bad++;
                $display("FAIL parity_event: got %h empty=%b expected %h", ev, e, ex);
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL parity_empty: got %b expected 1", empty);
        end
        $display("test_parity frame_err pulses %0d", err_cnt - err0);
    endtask

    task automatic test_overflow();
        logic [9:0] ev, ex;
        logic       e;
        logic [7:0] b;
        for (int i = 0; i < DEPTH + 1; i++) begin
            do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
            send_frame(b, 1'b0, 1'b0);
            model_byte(b);
        end
        n_cmp++;
        if (overflow !== m_ovf) begin
            n_bad++;
            $display("FAIL overflow_flag: got %b expected %b", overflow, m_ovf);
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            pop_event(ev, e);
            n_cmp++;
            if (e !== 1'b0 || ev !== ex) begin
                n_bad++;
                $display("FAIL overflow_event: got %h empty=%b expected %h", ev, e, ex);
            end
            $display("test_overflow event %h", ev);
        end
        n_cmp++;
        if ({empty, overflow} !== {1'b1, m_ovf}) begin
            n_bad++;
            $display("FAIL overflow_sticky: got empty,ovf=%b%b expected 1%b", empty, overflow, m_ovf);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        logic [9:0] ev, ex;
        logic       e;
        int         err0;
        send_frame(8'hF0, 1'b0, 1'b0);
        model_byte(8'hF0);
        err0 = err_cnt;
        ps2_send(frame_bits(8'h55, 1'b0), 4, 1'b0);
        repeat (TMO + 50) @(negedge clk);
        model_clear_flags();
        n_cmp++;
        if (err_cnt - err0 !== 1) begin
            n_bad++;
            $display("FAIL timeout_frame_err: got %0d pulses expected 1", err_cnt - err0);
        end
        send_frame(8'h29, 1'b0, 1'b0);
        model_byte(8'h29);
        ex = exp_q.pop_front();
        pop_event(ev, e);
        n_cmp++;
        if (e !== 1'b0 || ev !== ex) begin
            n_bad++;
            $display("FAIL timeout_next_event: got %h empty=%b expected %h", ev, e, ex);
        end
        $display("test_timeout event %h", ev);
    endtask

    task automatic test_glitch();
        logic [9:0] ev, ex;
        logic       e;
        int         err0;
        err0 = err_cnt;
        send_frame(8'h29, 1'b0, 1'b1);
        model_byte(8'h29);
        ex = exp_q.pop_front();
        pop_event(ev, e);
        n_cmp++;
        if (e !== 1'b0 || ev !== ex || err_cnt !== err0) begin
            n_bad++;
            $display("FAIL glitch_event: got %h empty=%b errs=%0d expected %h errs=0",
                     ev, e, err_cnt - err0, ex);
        end
        $display("test_glitch event %h", ev);
    endtask

    task automatic test_reset_midframe();
        logic [9:0] ev, ex;
        logic       e;
        send_frame(8'hE0, 1'b0, 1'b0);
        ps2_send(frame_bits(8'h3A, 1'b0), 5, 1'b0);
        do_reset();
        send_frame(8'h29, 1'b0, 1'b0);
        model_byte(8'h29);
        ex = exp_q.pop_front();
        pop_event(ev, e);
        n_cmp++;
        if (e !== 1'b0 || ev !== ex) begin
            n_bad++;
            $display("FAIL midframe_reset_event: got %h empty=%b expected %h", ev, e, ex);
        end
        $display("test_reset_midframe event %h", ev);
    endtask

    task automatic test_random();
        logic [9:0] ev, ex;
        logic       e;
        logic [7:0] b;
        int         r;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
            send_frame(b, 1'b0, 1'b0);
            model_byte(b);
            if ($urandom_range(0, 2) == 0) begin
                while (exp_q.size() > 0) begin
                    ex = exp_q.pop_front();
                    pop_event(ev, e);
                    n_cmp++;
                    if (e !== 1'b0 || ev !== ex) begin
                        n_bad++;
                        $display("FAIL random_event: got %h empty=%b expected %h", ev, e, ex);
                    end
                    $display("test_random event %h", ev);
                end
                // A read strobe on an empty FIFO must not disturb anything.
                pop_event(ev, e);
                n_cmp++;
                if (e !== 1'b1 || ev !== 10'd0) begin
                    n_bad++;
                    $display("FAIL random_empty_read: got %h empty=%b expected 000 empty=1", ev, e);
                end
            end
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            pop_event(ev, e);
            n_cmp++;
            if (e !== 1'b0 || ev !== ex) begin
                n_bad++;
                $display("FAIL random_final_event: got %h empty=%b expected %h", ev, e, ex);
            end
            $display("test_random event %h", ev);
        end
        n_cmp++;
        if ({empty, overflow} !== {1'b1, m_ovf}) begin
            n_bad++;
            $display("FAIL random_final_state: got empty,ovf=%b%b expected 1%b", empty, overflow, m_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_prefix();
        test_parity();
        test_overflow();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_keycode_receiver.md
PS2_KEYCODE_RECEIVER -- requirements
Module: ps2_keycode_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: key-event FIFO entries; power of two, 2..64.
REQ-002 Parameter FILTER_LEN, default 8: consecutive equal samples required to accept a ps2_clk/ps2_data level.
REQ-003 Parameter TIMEOUT_CYC, default 100000: clk cycles without a falling ps2_clk edge before an in-progress frame is abandoned.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-007 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-008 rd_en  input  1  pops one event when empty=0.
REQ-009 dout  output  8  scan code of the head event.
REQ-010 dout_brk  output  1  head event is a key release (F0 prefix).
REQ-011 dout_ext  output  1  head event is an extended key (E0 prefix).
REQ-012 empty  output  1  FIFO holds no events.
REQ-013 overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-014 frame_err  output  1  one-cycle pulse on a framing, parity or timeout error.

Function
REQ-015 Both PS/2 lines shall pass a 2-flop synchroniser, then a FILTER_LEN-sample glitch filter; a filtered ps2_clk 1->0 transition is a sample strobe.
REQ-016 Frame FSM states shall be IDLE, DATA, PARITY, STOP; on a strobe: IDLE->DATA if data=0 (start bit), otherwise stay in IDLE; DATA shifts 8 bits LSB-first and moves to PARITY after the 8th; PARITY->STOP; STOP->IDLE.
REQ-017 In STOP, data=1 shall complete a byte; data=0 shall pulse frame_err and discard the byte.
REQ-018 If the timeout counter reaches TIMEOUT_CYC in any state other than IDLE, the FSM shall return to IDLE, discard partial data and pulse frame_err; the counter clears on every strobe.
REQ-019 A completed byte 0xE0 shall set the ext flag; 0xF0 shall set the brk flag; neither shall produce an event.
REQ-020 Any other completed byte shall push {brk,ext,byte} into the FIFO one cycle after the STOP strobe, then clear both flags.
REQ-021 A frame error shall clear both prefix flags.
REQ-022 The FIFO shall be first-word-fall-through: dout/dout_brk/dout_ext show the head entry whenever empty=0; rd_en with empty=0 advances the head on the next edge; rd_en with empty=1 is ignored.
REQ-023 A push while full shall be dropped and shall set overflow; a simultaneous push and pop while full shall succeed with no overflow.
REQ-024 Read and write pointers shall wrap modulo FIFO_DEPTH; the count shall be $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-025 While rst_n=0: FSM=IDLE, shift register, prefix flags, timeout counter, filters (filtered level 1), and FIFO pointers cleared; dout=0x00, dout_brk=0, dout_ext=0, empty=1, overflow=0, frame_err=0.
REQ-026 A reset asserted mid-frame shall discard the partial frame; after release the FSM shall resynchronise on the next start bit.
REQ-027 overflow shall clear only on reset.

Configuration
REQ-028 With PS2_PARITY_CHECK_EN defined, the PARITY-state bit shall be checked for odd parity over data+parity; on mismatch the byte shall be discarded and frame_err pulsed at STOP.
REQ-029 Without PS2_PARITY_CHECK_EN, the parity bit shall be sampled and ignored.

Verification
REQ-030 Frame 0x1C (A make), good parity and stop -> one event dout=0x1C, brk=0, ext=0; empty falls 1 cycle after the STOP strobe.
REQ-031 Frames F0,1C -> single event 0x1C brk=1 ext=0; frames E0,F0,75 -> single event 0x75 brk=1 ext=1.
REQ-032 Frame 0x1C with wrong parity -> with PS2_PARITY_CHECK_EN: no event, frame_err pulse; without: event 0x1C.
REQ-033 FIFO_DEPTH+1 frames with rd_en=0 -> FIFO_DEPTH events read back in order, overflow=1; then rst_n low -> overflow=0, empty=1.
REQ-034 Start bit plus 3 data bits, then ps2_clk idle for TIMEOUT_CYC -> frame_err pulse, FSM back in IDLE; a following 0x29 frame is received correctly.
REQ-035 Glitches of FILTER_LEN-1 cycles on ps2_clk during a 0x29 frame -> no extra strobes; event 0x29 received.
